// File: rtl/point_counter.sv
`timescale 1ns/1ps
// point_counter: game-state and scoring stage ahead of animation.
// On every committed car position it scans the coins one per cycle for an
// overlap, requests the animation to erase each newly collected coin, keeps
// the collected-coin mask and score, and runs the countdown timer.
//
// Ports:
//   clock         system clock, all logic on posedge
//   reset         synchronous active-high reset
//   start         level; starts/restarts a game from IDLE, WON or TIMEUP
//   posValid      1-cycle pulse: carX/carY hold a newly committed position
//   carX, carY    car position (8-bit X, 7-bit Y)
//   coinEraseAck  animation finished erasing coin coinIdx
//   coinErase_en  erase request for coin coinIdx, held until acknowledged
//   coinIdx       coin being erased
//   memQoutPC     collected-coin mask, bit i = coin i taken
//   score         accumulated points, saturating
//   secondsLeft   remaining game seconds
//   won           high while in WON
//   timesUp       high while in TIMEUP
module point_counter #(
    parameter int unsigned NUM_COINS = 4,
    parameter logic [8*NUM_COINS-1:0] COIN_XS = {8'd120, 8'd80, 8'd40, 8'd20},
    parameter logic [7*NUM_COINS-1:0] COIN_YS = {7'd100, 7'd60, 7'd30, 7'd10},
    parameter int unsigned HIT_RADIUS = 4,
    parameter int unsigned POINTS_PER_COIN = 10,
    parameter int unsigned TIME_LIMIT = 60,
    parameter int unsigned CLK_PER_SEC = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        posValid,
    input  logic [7:0]  carX,
    input  logic [6:0]  carY,
    input  logic        coinEraseAck,
    output logic        coinErase_en,
    output logic [3:0]  coinIdx,
    output logic [15:0] memQoutPC,
    output logic [15:0] score,
    output logic [7:0]  secondsLeft,
    output logic        won,
    output logic        timesUp
);

    localparam int unsigned PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_COINS - 1);
    localparam logic [15:0] FULL_MASK = 16'((33'd1 << NUM_COINS) - 33'd1);

    typedef enum logic [2:0] {IDLE, PLAY, CHECK, ERASE, WON, TIMEUP} stateT;

    stateT            state, stateNext;
    logic [7:0]       carXq, carXNext;
    logic [6:0]       carYq, carYNext;
    logic [3:0]       idx, idxNext;
    logic [15:0]      maskNext, scoreNext;
    logic [7:0]       secondsNext;
    logic [PRE_W-1:0] prescaler, prescalerNext;
    logic [3:0]       coinIdxNext;
    logic             eraseNext;
    logic [15:0]      hitVec;
    logic [16:0]      scoreSum;
    logic             timerRun;

    function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Overlap of the latched car position with every coin; Y compared at 8 bits.
    always_comb begin
        hitVec = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            hitVec[i] = ({1'b0, absDiff(carXq, COIN_XS[8*i +: 8])} < 9'(HIT_RADIUS)) &&
                        ({1'b0, absDiff({1'b0, carYq}, {1'b0, COIN_YS[7*i +: 7]})} < 9'(HIT_RADIUS));
        end
    end

    assign timerRun = (state == PLAY) || (state == CHECK) || (state == ERASE);

    // Next-state and next-value logic for the FSM, timer and scoring datapath.
    always_comb begin
        stateNext     = state;
        carXNext      = carXq;
        carYNext      = carYq;
        idxNext       = idx;
        maskNext      = memQoutPC;
        scoreNext     = score;
        secondsNext   = secondsLeft;
        prescalerNext = prescaler;
        coinIdxNext   = coinIdx;
        eraseNext     = coinErase_en;
        scoreSum      = {1'b0, score} + 17'(POINTS_PER_COIN);

        // Countdown only while a game is in progress; holds at zero.
        if (timerRun) begin
            if (prescaler == PRE_MAX) begin
                prescalerNext = '0;
                if (secondsLeft != 8'd0) begin
                    secondsNext = secondsLeft - 8'd1;
                end
            end else begin
                prescalerNext = prescaler + PRE_W'(1);
            end
        end

        case (state)
            IDLE, WON, TIMEUP: begin
                if (start) begin
                    maskNext      = '0;
                    scoreNext     = '0;
                    secondsNext   = 8'(TIME_LIMIT);
                    prescalerNext = '0;
                    idxNext       = '0;
                    stateNext     = PLAY;
                end
            end
            PLAY: begin
                if (posValid) begin
                    carXNext  = carX;
                    carYNext  = carY;
                    idxNext   = '0;
                    stateNext = CHECK;
                end else if (secondsLeft == 8'd0) begin
                    stateNext = TIMEUP;
                end
            end
            CHECK: begin
                if (hitVec[idx] && !memQoutPC[idx]) begin
                    maskNext[idx] = 1'b1;
                    scoreNext     = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
                    coinIdxNext   = idx;
                    eraseNext     = 1'b1;
                    stateNext     = ERASE;
                end else if (idx == LAST_IDX) begin
                    stateNext = PLAY;
                end else begin
                    idxNext = idx + 4'd1;
                end
            end
            ERASE: begin
                if (coinEraseAck) begin
                    eraseNext = 1'b0;
                    // A full mask beats a timer that expires on the same cycle.
                    if (memQoutPC == FULL_MASK) begin
                        stateNext = WON;
                    end else if (secondsLeft == 8'd0) begin
                        stateNext = TIMEUP;
                    end else if (idx == LAST_IDX) begin
                        stateNext = PLAY;
                    end else begin
                        idxNext   = idx + 4'd1;
                        stateNext = CHECK;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers; won/timesUp register the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            carXq        <= '0;
            carYq        <= '0;
            idx          <= '0;
            memQoutPC    <= '0;
            score        <= '0;
            secondsLeft  <= 8'(TIME_LIMIT);
            prescaler    <= '0;
            coinIdx      <= '0;
            coinErase_en <= 1'b0;
            won          <= 1'b0;
            timesUp      <= 1'b0;
        end else begin
            state        <= stateNext;
            carXq        <= carXNext;
            carYq        <= carYNext;
            idx          <= idxNext;
            memQoutPC    <= maskNext;
            score        <= scoreNext;
            secondsLeft  <= secondsNext;
            prescaler    <= prescalerNext;
            coinIdx      <= coinIdxNext;
            coinErase_en <= eraseNext;
            won          <= (stateNext == WON);
            timesUp      <= (stateNext == TIMEUP);
        end
    end

endmodule
